// File: rtl/wb_stage_piped_pkg.sv
// ----------------------------------------------------------------------------
// wb_stage_piped_pkg
//
// Purpose:
//    Shared definitions for the registered writeback stage. This package holds
//    the writeback source selector codes, which the decode and MEM stages also
//    produce, and the writeback FSM state encoding.
//
// Contents:
//    WB_OP_W     width of the writeback source selector
//    wb_op_e     WB_ALU / WB_MEM / WB_FLAG / WB_LINK
//    wb_state_e  IDLE / WAIT / HOLD
//    isMemOp()   true when a selector code names the load-data source
// ----------------------------------------------------------------------------
package wb_stage_piped_pkg;

    localparam int WB_OP_W = 2;

    // Writeback source selector. The encoding is shared with the MEM/WB
    // pipeline register, so the numeric values must not change.
    typedef enum logic [WB_OP_W-1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_FLAG = 2'd2,
        WB_LINK = 2'd3
    } wb_op_e;

    // Writeback FSM states.
    //    IDLE : nothing held
    //    WAIT : a load has been accepted but its data has not arrived yet
    //    HOLD : final data is registered and commits this cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } wb_state_e;

    // Only loads have variable latency, so only they can stall the stage.
    function automatic logic isMemOp(input logic [WB_OP_W-1:0] op);
        return wb_op_e'(op) == WB_MEM;
    endfunction

endpackage : wb_stage_piped_pkg

// File: rtl/wb_stage_piped_select.sv
// ----------------------------------------------------------------------------
// wb_select
//
// Purpose:
//    Purely combinational writeback source mux. It picks the value that will
//    be written to the register file from the ALU result, the load data, the
//    compare flag (zero-extended) or the link value (PC+2). It contains no
//    arithmetic: every source is already DATA_W wide or is zero-extended.
//
// Parameters:
//    DATA_W      datapath width
//
// Ports:
//    wb_op_i     source selector (wb_op_e encoding)
//    alu_i       ALU result
//    mem_i       load data
//    next_pc_i   PC+2, used as the link value
//    flag_i      compare / branch flag
//    data_o      selected writeback data
// ----------------------------------------------------------------------------
module wb_select
    import wb_stage_piped_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [WB_OP_W-1:0] wb_op_i,
    input  logic [DATA_W-1:0]  alu_i,
    input  logic [DATA_W-1:0]  mem_i,
    input  logic [DATA_W-1:0]  next_pc_i,
    input  logic               flag_i,
    output logic [DATA_W-1:0]  data_o
);

    // The flag source is a single bit widened with zeros so that SLT-style
    // instructions write exactly 0 or 1 into the destination register.
    always_comb begin
        data_o = alu_i;
        case (wb_op_e'(wb_op_i))
            WB_ALU:  data_o = alu_i;
            WB_MEM:  data_o = mem_i;
            WB_FLAG: data_o = {{(DATA_W-1){1'b0}}, flag_i};
            WB_LINK: data_o = next_pc_i;
            default: data_o = alu_i;
        endcase
    end

endmodule : wb_select

// File: rtl/wb_stage_piped.sv
// ----------------------------------------------------------------------------
// wb_stage_piped
//
// Purpose:
//    Registered writeback stage for the pipelined core. It accepts one MEM/WB
//    instruction per cycle, selects its writeback data, waits for late load
//    data when needed, and then drives a single-cycle register-file write.
//    It also reports retirement, a sticky halt and a sticky load-error flag.
//
// Configuration:
//    WB_FWD_EN   when defined, the fwd_* port mirrors the register-file write
//                so decode can pick the value up in the same cycle. When not
//                defined, fwd_* are tied to zero.
//
// Parameters:
//    DATA_W      width of datapath, register data and PC
//    RADDR_W     register-file address width
//
// Ports:
//    clk, rst_n                 clock, asynchronous active-low reset
//    in_valid / in_ready        MEM-stage handshake
//    in_wb_op                   writeback source selector
//    in_alu_out                 ALU result
//    in_next_pc                 PC+2 link value
//    in_flag                    compare / branch flag
//    in_rd, in_reg_we           destination register and its write enable
//    in_halt                    instruction is HALT
//    mem_rdy, mem_data, mem_err load data handshake and fault
//    rf_we, rf_waddr, rf_wdata  register-file write port
//    retire                     one instruction retired this cycle
//    halted                     sticky, a HALT has retired
//    err                        sticky, a load reported a fault
//    fwd_valid, fwd_rd, fwd_data  forwarding port (WB_FWD_EN only)
// ----------------------------------------------------------------------------
module wb_stage_piped
    import wb_stage_piped_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WB_OP_W-1:0] in_wb_op,
    input  logic [DATA_W-1:0]  in_alu_out,
    input  logic [DATA_W-1:0]  in_next_pc,
    input  logic               in_flag,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_reg_we,
    input  logic               in_halt,

    input  logic               mem_rdy,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               mem_err,

    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,

    output logic               retire,
    output logic               halted,
    output logic               err,

    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]  fwd_data
);

    wb_state_e           state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [RADDR_W-1:0]  rd_q, rd_d;
    logic                reg_we_q, reg_we_d;
    logic                halt_q, halt_d;
    logic                halted_q, halted_d;
    logic                err_q, err_d;

    logic                accept;
    logic                acceptMem;
    logic [DATA_W-1:0]   selData;

    // Source mux. The load data input is wired straight to mem_data so a load
    // whose data is already valid at accept time goes directly to HOLD.
    wb_select #(
        .DATA_W (DATA_W)
    ) u_select (
        .wb_op_i   (in_wb_op),
        .alu_i     (in_alu_out),
        .mem_i     (mem_data),
        .next_pc_i (in_next_pc),
        .flag_i    (in_flag),
        .data_o    (selData)
    );

    // The stage can take a new instruction while idle or while the previous
    // one is committing, which gives one instruction per cycle back to back.
    // Only an outstanding load or a retired HALT blocks it.
    assign in_ready  = !halted_q && (state_q != WAIT);
    assign accept    = in_valid && in_ready;
    assign acceptMem = accept && isMemOp(in_wb_op);

    // Next-state logic. Every register defaults to holding its value; the
    // destination fields are only reloaded on an accept, so they stay stable
    // for the whole WAIT period of a late load.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rd_d     = rd_q;
        reg_we_d = reg_we_q;
        halt_d   = halt_q;
        err_d    = err_q;
        // halted latches at the end of the cycle in which a HALT commits.
        halted_d = halted_q || ((state_q == HOLD) && halt_q);

        case (state_q)
            IDLE, HOLD: begin
                state_d = IDLE;
                if (accept) begin
                    rd_d     = in_rd;
                    reg_we_d = in_reg_we;
                    halt_d   = in_halt;
                    data_d   = selData;
                    if (acceptMem && !mem_rdy) begin
                        state_d = WAIT;
                    end else begin
                        state_d = HOLD;
                    end
                    // A fault is only meaningful alongside valid load data.
                    if (acceptMem && mem_rdy && mem_err) begin
                        err_d = 1'b1;
                    end
                end
            end

            WAIT: begin
                if (mem_rdy) begin
                    data_d  = mem_data;
                    state_d = HOLD;
                    if (mem_err) begin
                        err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers. Reset drops any pending load without writing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            rd_q     <= '0;
            reg_we_q <= 1'b0;
            halt_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rd_q     <= rd_d;
            reg_we_q <= reg_we_d;
            halt_q   <= halt_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // HOLD lasts exactly one cycle per instruction, so these strobes are
    // single-cycle pulses without any extra edge detection.
    assign retire   = (state_q == HOLD);
    assign rf_we    = (state_q == HOLD) && reg_we_q;
    assign rf_waddr = rd_q;
    assign rf_wdata = data_q;
    assign halted   = halted_q;
    assign err      = err_q;

`ifdef WB_FWD_EN
    // Decode samples this in the same cycle the register file is written, so
    // it sees the new value without a write-through regfile.
    assign fwd_valid = (state_q == HOLD) && reg_we_q;
    assign fwd_rd    = rd_q;
    assign fwd_data  = data_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule : wb_stage_piped

// File: tb/tb_wb_stage_piped.sv
// ----------------------------------------------------------------------------
// tb_wb_stage_piped
//
// Self-checking bench for wb_stage_piped. A transaction-level reference model
// tracks which instruction should commit on each cycle, whether a load is
// outstanding, and the sticky halt/error flags.
// ----------------------------------------------------------------------------
module tb_wb_stage_piped;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_wb_op;
    logic [DATA_W-1:0]  in_alu_out;
    logic [DATA_W-1:0]  in_next_pc;
    logic               in_flag;
    logic [RADDR_W-1:0] in_rd;
    logic               in_reg_we;
    logic               in_halt;
    logic               mem_rdy;
    logic [DATA_W-1:0]  mem_data;
    logic               mem_err;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic               retire;
    logic               halted;
    logic               err;
    logic               fwd_valid;
    logic [RADDR_W-1:0] fwd_rd;
    logic [DATA_W-1:0]  fwd_data;

    int checks   = 0;
    int failures = 0;

    // Reference model: the instruction committing this cycle, the load that
    // is waiting for data, and the sticky flags.
    logic               mPend;
    logic [RADDR_W-1:0] mRd;
    logic               mWe;
    logic               mHalt;
    logic [DATA_W-1:0]  mData;
    logic               mWaiting;
    logic [RADDR_W-1:0] wRd;
    logic               wWe;
    logic               wHalt;
    logic               mHalted;
    logic               mErr;

    // Clock generation
    always #5 clk = ~clk;

    wb_stage_piped #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_wb_op   (in_wb_op),
        .in_alu_out (in_alu_out),
        .in_next_pc (in_next_pc),
        .in_flag    (in_flag),
        .in_rd      (in_rd),
        .in_reg_we  (in_reg_we),
        .in_halt    (in_halt),
        .mem_rdy    (mem_rdy),
        .mem_data   (mem_data),
        .mem_err    (mem_err),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .retire     (retire),
        .halted     (halted),
        .err        (err),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
    );

    // Writeback value straight from the instruction-set meaning of each op.
    function automatic logic [DATA_W-1:0] expData(input logic [1:0] op,
                                                  input logic [DATA_W-1:0] alu,
                                                  input logic [DATA_W-1:0] md,
                                                  input logic [DATA_W-1:0] pc,
                                                  input logic fl);
        case (op)
            2'd0:    return alu;
            2'd1:    return md;
            2'd2:    return (fl ? 16'd1 : 16'd0);
            default: return pc;
        endcase
    endfunction

    // Clears the model the way a reset clears the stage.
    task automatic modelReset();
        mPend    = 1'b0;
        mRd      = '0;
        mWe      = 1'b0;
        mHalt    = 1'b0;
        mData    = '0;
        mWaiting = 1'b0;
        wRd      = '0;
        wWe      = 1'b0;
        wHalt    = 1'b0;
        mHalted  = 1'b0;
        mErr     = 1'b0;
    endtask

    // One clock cycle: drive inputs (called at posedge+1), check in_ready,
    // advance the model, then check the registered outputs at the next
    // posedge+1.
    task automatic cycle(input logic v, input logic [1:0] op,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] pc,
                         input logic fl, input logic [RADDR_W-1:0] rd,
                         input logic we, input logic hl, input logic mr,
                         input logic [DATA_W-1:0] md, input logic me);
        logic               expReady;
        logic               nPend;
        logic [RADDR_W-1:0] nRd;
        logic               nWe;
        logic               nHalt;
        logic [DATA_W-1:0]  nData;

        in_valid   = v;
        in_wb_op   = op;
        in_alu_out = alu;
        in_next_pc = pc;
        in_flag    = fl;
        in_rd      = rd;
        in_reg_we  = we;
        in_halt    = hl;
        mem_rdy    = mr;
        mem_data   = md;
        mem_err    = me;
        #1;

        expReady = !mHalted && !mWaiting;
        checks++;
        if (in_ready !== expReady) begin
            failures++;
            $display("[TB] FAIL in_ready: got %b expected %b at %0t", in_ready, expReady, $time);
        end

        // A HALT committing this cycle makes halted visible from next cycle.
        if (mPend && mHalt) mHalted = 1'b1;

        nPend = 1'b0;
        nRd   = '0;
        nWe   = 1'b0;
        nHalt = 1'b0;
        nData = '0;
        if (mWaiting) begin
            if (mr) begin
                nPend    = 1'b1;
                nRd      = wRd;
                nWe      = wWe;
                nHalt    = wHalt;
                nData    = md;
                mWaiting = 1'b0;
                if (me) mErr = 1'b1;
            end
        end else if (v && expReady) begin
            if (op == 2'd1 && !mr) begin
                mWaiting = 1'b1;
                wRd      = rd;
                wWe      = we;
                wHalt    = hl;
            end else begin
                nPend = 1'b1;
                nRd   = rd;
                nWe   = we;
                nHalt = hl;
                nData = expData(op, alu, md, pc, fl);
                if (op == 2'd1 && me) mErr = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        mPend = nPend;
        mRd   = nRd;
        mWe   = nWe;
        mHalt = nHalt;
        mData = nData;

        checks++;
        if (retire !== mPend) begin
            failures++;
            $display("[TB] FAIL retire: got %b expected %b at %0t", retire, mPend, $time);
        end
        checks++;
        if (rf_we !== (mPend && mWe)) begin
            failures++;
            $display("[TB] FAIL rf_we: got %b expected %b at %0t", rf_we, mPend && mWe, $time);
        end
        checks++;
        if (halted !== mHalted) begin
            failures++;
            $display("[TB] FAIL halted: got %b expected %b at %0t", halted, mHalted, $time);
        end
        checks++;
        if (err !== mErr) begin
            failures++;
            $display("[TB] FAIL err: got %b expected %b at %0t", err, mErr, $time);
        end
        if (mPend) begin
            checks++;
            if (rf_waddr !== mRd) begin
                failures++;
                $display("[TB] FAIL rf_waddr: got %0d expected %0d at %0t", rf_waddr, mRd, $time);
            end
            checks++;
            if (rf_wdata !== mData) begin
                failures++;
                $display("[TB] FAIL rf_wdata: got %h expected %h at %0t", rf_wdata, mData, $time);
            end
        end
`ifdef WB_FWD_EN
        checks++;
        if (fwd_valid !== (mPend && mWe)) begin
            failures++;
            $display("[TB] FAIL fwd_valid: got %b expected %b at %0t", fwd_valid, mPend && mWe, $time);
        end
        if (mPend && mWe) begin
            checks++;
            if (fwd_rd !== mRd || fwd_data !== mData) begin
                failures++;
                $display("[TB] FAIL fwd_port: got %0d/%h expected %0d/%h", fwd_rd, fwd_data, mRd, mData);
            end
        end
`else
        checks++;
        if (fwd_valid !== 1'b0 || fwd_rd !== '0 || fwd_data !== '0) begin
            failures++;
            $display("[TB] FAIL fwd_tied: got %b/%0d/%h expected 0/0/0", fwd_valid, fwd_rd, fwd_data);
        end
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 2'd0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    // Checks that every registered output reads zero while reset is held.
    task automatic checkResetOutputs(input string tag);
        checks++;
        if (rf_we !== 1'b0 || retire !== 1'b0 || halted !== 1'b0 || err !== 1'b0 ||
            rf_waddr !== '0 || rf_wdata !== '0 || fwd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s: got we=%b ret=%b hlt=%b err=%b addr=%0d data=%h fwd=%b expected all 0",
                     tag, rf_we, retire, halted, err, rf_waddr, rf_wdata, fwd_valid);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_wb_op   = '0;
        in_alu_out = '0;
        in_next_pc = '0;
        in_flag    = 1'b0;
        in_rd      = '0;
        in_reg_we  = 1'b0;
        in_halt    = 1'b0;
        mem_rdy    = 1'b0;
        mem_data   = '0;
        mem_err    = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset_outputs");
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        $display("[TB] test_alu");
        cycle(1'b1, 2'd0, 16'h1234, 16'h0000, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        idle(1);
    endtask

    task automatic test_flag();
        $display("[TB] test_flag");
        cycle(1'b1, 2'd2, 16'hFFFF, 16'h0000, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 2'd2, 16'hFFFF, 16'h0000, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        idle(1);
    endtask

    task automatic test_load_wait();
        $display("[TB] test_load_wait");
        cycle(1'b1, 2'd1, 16'h0000, 16'h0000, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        // Offered instructions must be refused while the load is outstanding.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'd0, 16'h5555, 16'h0000, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        end
        cycle(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        // Load with data already valid at accept time.
        cycle(1'b1, 2'd1, 16'h0000, 16'h0000, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 16'hCAFE, 1'b0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'd0, 16'hA000 + 16'(i), 16'h0000, 1'b0, 3'(i + 1), 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        end
        idle(1);
    endtask

    task automatic test_link();
        $display("[TB] test_link");
        cycle(1'b1, 2'd3, 16'h9999, 16'h0042, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        idle(1);
    endtask

    task automatic test_mem_err();
        $display("[TB] test_mem_err");
        // Ignored: fault on a non-load and fault with mem_rdy low.
        cycle(1'b1, 2'd0, 16'h0011, 16'h0000, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 16'h7777, 1'b1);
        cycle(1'b1, 2'd1, 16'h0000, 16'h0000, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h1357, 1'b1);
        idle(2);
    endtask

    task automatic test_random();
        logic [1:0] op;
        $display("[TB] test_random");
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), op, 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                  16'($urandom), ($urandom_range(0, 7) == 0));
        end
        idle(4);
    endtask

    task automatic test_reset_in_wait();
        $display("[TB] test_reset_in_wait");
        cycle(1'b1, 2'd1, 16'h0000, 16'h0000, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("reset_in_wait");
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Late data for the dropped load must not produce a write.
        cycle(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0);
        idle(1);
    endtask

    task automatic test_halt();
        $display("[TB] test_halt");
        cycle(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        idle(1);
        // Once halted, offered instructions are refused indefinitely.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'd0, 16'h4321, 16'h0000, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_flag();
        test_load_wait();
        test_back_to_back();
        test_link();
        test_mem_err();
        test_random();
        test_reset_in_wait();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule : tb_wb_stage_piped
